// File: rtl/spi_cmd_trace_ctrl_if.sv
// Avalon-MM host port of the SPI command trace controller.
// The host drives address/read/write/writedata; the trace controller answers.
interface spi_cmd_trace_ctrl_if;
  logic [6:0]  address;
  logic        read;
  logic        write;
  logic [63:0] writedata;
  logic [63:0] readdata;
  logic        waitrequest;

  modport master (output address, read, write, writedata, input readdata, waitrequest);
  modport slave  (input address, read, write, writedata, output readdata, waitrequest);
endinterface

// File: rtl/spi_cmd_trace_ctrl.sv
// SPI command trace capture controller: filters accepted commands into a ring-buffer
// log RAM and arbitrates that single-port RAM with Avalon-MM host reads and CSRs.
module spi_cmd_trace_ctrl #(
  parameter int DEPTH_LOG2 = 6,
  parameter int CMD_W      = 6,
  parameter int ARG_W      = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [CMD_W-1:0]          io_Command,
  input  logic [ARG_W-1:0]          io_CommandArgument,
  input  logic                      io_ReadSuccess,
  spi_cmd_trace_ctrl_if.slave       io_Avalon,
  output logic [DEPTH_LOG2-1:0]     ram_addr,
  output logic [CMD_W+ARG_W-1:0]    ram_wdata,
  output logic                      ram_we,
  output logic                      ram_re,
  input  logic [CMD_W+ARG_W-1:0]    ram_rdata,
  output logic                      irq
);
  localparam int W     = CMD_W + ARG_W;
  localparam int CNT_W = DEPTH_LOG2 + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(1 << DEPTH_LOG2);

  typedef enum logic [1:0] {IDLE = 2'd0, CAP_WR = 2'd1, H_RD = 2'd2, H_RSP = 2'd3} state_t;

  state_t                state_r;
  logic [DEPTH_LOG2-1:0] wr_ptr_r;
  logic [CNT_W-1:0]      count_r;
  logic [CNT_W-1:0]      thresh_r;
  logic                  full_r, ovf_r, armed_r, wrap_r, filt_en_r;
  logic                  pending_r, rs_hist_r, irq_en_r;
  logic [CMD_W-1:0]      filt_cmd_r;
  logic [15:0]           dropped_r;

  logic                  event_s, log_sel_s, log_hit_s, csr_wr_s, clear_s;
  logic                  drop_evt_s, drop_wr_s;
  logic [DEPTH_LOG2-1:0] offset_s;
  logic [1:0]            csr_sel_s;
  logic [16:0]           dropped_sum_s;
  logic [63:0]           csr_rd_s;
  logic [63:0]           wd_s;

  // Event detection, host decode, drop accounting and CSR read mux
  always_comb begin
    wd_s          = io_Avalon.writedata;
    offset_s      = io_Avalon.address[DEPTH_LOG2-1:0];
    log_sel_s     = io_Avalon.address[6];
    csr_sel_s     = io_Avalon.address[1:0];
    log_hit_s     = io_Avalon.read & log_sel_s & ({1'b0, offset_s} < count_r);
    event_s       = io_ReadSuccess & ~rs_hist_r & armed_r &
                    (~filt_en_r | (io_Command == filt_cmd_r));
    csr_wr_s      = io_Avalon.write & ~log_sel_s;
    clear_s       = csr_wr_s & (csr_sel_s == 2'd0) & wd_s[3];
    drop_evt_s    = event_s & pending_r & ~clear_s;
    // A CAP_WR cycle without a write strobe is a suppressed (stop-mode full) write
    drop_wr_s     = (state_r == CAP_WR) & ~ram_we & ~clear_s;
    dropped_sum_s = {1'b0, dropped_r} + {16'd0, drop_evt_s} + {16'd0, drop_wr_s};

    csr_rd_s = 64'd0;
    case (csr_sel_s)
      2'd0: begin
        csr_rd_s[0]          = armed_r;
        csr_rd_s[1]          = wrap_r;
        csr_rd_s[2]          = filt_en_r;
        csr_rd_s[8 +: CMD_W] = filt_cmd_r;
      end
      2'd1: begin
        csr_rd_s[CNT_W-1:0]       = count_r;
        csr_rd_s[16 +: DEPTH_LOG2] = wr_ptr_r;
        csr_rd_s[24]              = full_r;
        csr_rd_s[25]              = ovf_r;
        csr_rd_s[26]              = armed_r;
        csr_rd_s[27]              = pending_r;
        csr_rd_s[31:28]           = {2'b00, state_r};
      end
      2'd2: csr_rd_s[15:0] = dropped_r;
      2'd3: begin
        csr_rd_s[CNT_W-1:0] = thresh_r;
        csr_rd_s[8]         = irq_en_r;
      end
      default: csr_rd_s = 64'd0;
    endcase

    if (io_Avalon.read & log_sel_s) begin
      io_Avalon.readdata = (state_r == H_RSP) ? {{(64-W){1'b0}}, ram_rdata} : 64'd0;
    end else if (io_Avalon.read) begin
      io_Avalon.readdata = csr_rd_s;
    end else begin
      io_Avalon.readdata = 64'd0;
    end
    io_Avalon.waitrequest = log_hit_s & (state_r != H_RSP);
  end

  // Capture/host arbitration FSM, ring pointers, CSRs and registered RAM/irq outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= IDLE;
      wr_ptr_r   <= '0;
      count_r    <= '0;
      thresh_r   <= '0;
      full_r     <= 1'b0;
      ovf_r      <= 1'b0;
      armed_r    <= 1'b0;
      wrap_r     <= 1'b0;
      filt_en_r  <= 1'b0;
      filt_cmd_r <= '0;
      pending_r  <= 1'b0;
      rs_hist_r  <= 1'b1;
      irq_en_r   <= 1'b0;
      dropped_r  <= 16'd0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      ram_we     <= 1'b0;
      ram_re     <= 1'b0;
      irq        <= 1'b0;
    end else begin
      rs_hist_r <= io_ReadSuccess;
      ram_we    <= 1'b0;
      ram_re    <= 1'b0;
      irq       <= irq_en_r & (thresh_r != CNT_W'(0)) & (count_r >= thresh_r);
      dropped_r <= dropped_sum_s[16] ? 16'hFFFF : dropped_sum_s[15:0];
      if (event_s & ~pending_r) begin
        pending_r <= 1'b1;
        ram_wdata <= {io_Command, io_CommandArgument};
      end

      case (state_r)
        IDLE: begin
          if (pending_r) begin
            state_r  <= CAP_WR;
            ram_addr <= wr_ptr_r;
            ram_we   <= ~((count_r == FULL_CNT) & ~wrap_r);
          end else if (log_hit_s) begin
            state_r  <= H_RD;
            ram_re   <= 1'b1;
            ram_addr <= wr_ptr_r - count_r[DEPTH_LOG2-1:0] + offset_s;
          end else begin
            state_r <= IDLE;
          end
        end
        CAP_WR: begin
          state_r   <= IDLE;
          pending_r <= 1'b0;
          if (ram_we) begin
            wr_ptr_r <= wr_ptr_r + DEPTH_LOG2'(1);
            if (count_r != FULL_CNT) begin
              count_r <= count_r + CNT_W'(1);
              if ((count_r == FULL_CNT - CNT_W'(1)) && !wrap_r) begin
                full_r  <= 1'b1;
                armed_r <= 1'b0;
              end
            end else begin
              ovf_r <= 1'b1;
            end
          end
        end
        H_RD:    state_r <= H_RSP;
        H_RSP:   state_r <= IDLE;
        default: state_r <= IDLE;
      endcase

      // CSR writes come last so a clear overrides capture bookkeeping
      if (csr_wr_s) begin
        case (csr_sel_s)
          2'd0: begin
            wrap_r     <= wd_s[1];
            filt_en_r  <= wd_s[2];
            filt_cmd_r <= wd_s[8 +: CMD_W];
            if (wd_s[3]) begin
              armed_r   <= wd_s[0];
              wr_ptr_r  <= '0;
              count_r   <= '0;
              full_r    <= 1'b0;
              ovf_r     <= 1'b0;
              dropped_r <= 16'd0;
              pending_r <= 1'b0;
            end else begin
              armed_r <= wd_s[0] & ~(full_r & ~wrap_r);
            end
          end
          2'd3: begin
            thresh_r <= wd_s[CNT_W-1:0];
            irq_en_r <= wd_s[8];
          end
          default: begin
          end
        endcase
      end
    end
  end
endmodule
